// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester shared-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef logic req_idx_t;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not served last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   last_served_i,
    output req_idx_t   grant_o
);

    // Pure combinational pick; the caller only uses grant_o when req_i is non-zero
    always_comb begin
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_served_i;
            default: grant_o = 1'b0;
        endcase
    end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// Optional wait timeout compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        owner,
    output logic        timeout_err
);

    arb_state_t state_q, state_d;
    req_idx_t   owner_q, owner_d;
    req_idx_t   last_served_q, last_served_d;
    req_idx_t   grant_s;
    logic       owner_valid_s;
    logic       timeout_hit_s;

    rr_arb2 u_rr_arb2 (
        .req_i         ({m1_valid, m0_valid}),
        .last_served_i (last_served_q),
        .grant_o       (grant_s)
    );

    assign owner_valid_s = owner_q ? m1_valid : m0_valid;
    assign owner         = owner_q;
    assign s_addr        = owner_q ? m1_addr  : m0_addr;
    assign s_wdata       = owner_q ? m1_wdata : m0_wdata;
    assign s_wstrb       = owner_q ? m1_wstrb : m0_wstrb;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q;

    assign timeout_hit_s = (state_q == BUSY) && (wait_cnt_q == TIMEOUT_LIM);
    assign timeout_err   = timeout_err_q;

    // Wait counter: held at zero outside BUSY, counts stalled BUSY cycles
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q != BUSY) begin
            wait_cnt_d = 16'd0;
        end else if (!timeout_hit_s && !s_ready) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Wait counter and sticky timeout flag registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_q | timeout_hit_s;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Next-state, grant bookkeeping and requester-side handshake outputs
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        s_valid       = 1'b0;
        m0_ready      = 1'b0;
        m1_ready      = 1'b0;
        m0_rdata      = s_rdata;
        m1_rdata      = s_rdata;
        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d = BUSY;
                    owner_d = grant_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (timeout_hit_s) begin
                    // Forced completion: memory is not driven and its ready is ignored
                    state_d       = IDLE;
                    last_served_d = owner_q;
                    if (owner_q) begin
                        m1_ready = 1'b1;
                        m1_rdata = ARB_TIMEOUT_RDATA;
                    end else begin
                        m0_ready = 1'b1;
                        m0_rdata = ARB_TIMEOUT_RDATA;
                    end
                end else if (!owner_valid_s) begin
                    // Owner abandoned its request: drop it without crediting a service
                    state_d = IDLE;
                end else begin
                    s_valid  = 1'b1;
                    m0_ready = (owner_q == 1'b0) && s_ready;
                    m1_ready = (owner_q == 1'b1) && s_ready;
                    if (s_ready) begin
                        state_d       = IDLE;
                        last_served_d = owner_q;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, owner and round-robin pointer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
        end
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus reset and timeout sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        owner, timeout_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .owner(owner), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0v, m1v;
        logic [31:0] m0a, m1a, m1wd;
        logic [3:0]  m1ws;
        logic        sr;
        logic [31:0] srd;
        logic        e_sv, e_r0, e_r1, e_own;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_ws;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic m0v, logic m1v, logic [31:0] m0a, logic [31:0] m1a,
                                logic [31:0] m1wd, logic [3:0] m1ws, logic sr, logic [31:0] srd,
                                logic e_sv, logic e_r0, logic e_r1, logic e_own,
                                logic [31:0] e_addr, logic [31:0] e_wd, logic [3:0] e_ws);
        vec_t v;
        v.m0v = m0v; v.m1v = m1v; v.m0a = m0a; v.m1a = m1a; v.m1wd = m1wd; v.m1ws = m1ws;
        v.sr = sr; v.srd = srd; v.e_sv = e_sv; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_own = e_own;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_ws = e_ws;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] W1 = 32'h2222_2222;
    localparam logic [31:0] WR = 32'hAABB_CCDD;

    initial begin
        resetn   = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr  = 32'h100; m1_addr = 32'h200;
        m0_wdata = W0; m1_wdata = W1;
        m0_wstrb = 4'h0; m1_wstrb = 4'hF;
        s_ready  = 1'b0; s_rdata = 32'h0;

        // Tie after reset, then held ties alternate m0,m1,m0,m1
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,0,32'h0,     0,0,0,0,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'hA1,    1,1,0,0,32'h100,W0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'h0,     0,0,0,0,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'hA3,    1,0,1,1,32'h200,W1,4'hF));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'h0,     0,0,0,1,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'hA5,    1,1,0,0,32'h100,W0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'h0,     0,0,0,0,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'hA7,    1,0,1,1,32'h200,W1,4'hF));
        // m0 read of 0x100 with one-cycle memory
        vecs.push_back(mk(1,0,32'h100,32'h200,W1,4'hF,0,32'h0,     0,0,0,1,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,0,32'h100,32'h200,W1,4'hF,0,32'h0,     1,0,0,0,32'h100,W0,4'h0));
        vecs.push_back(mk(1,0,32'h100,32'h200,W1,4'hF,1,32'h12345678,1,1,0,0,32'h100,W0,4'h0));
        vecs.push_back(mk(0,0,32'h100,32'h200,W1,4'hF,0,32'h0,     0,0,0,0,32'h0,32'h0,4'h0));
        // m1 partial write to 0x40
        vecs.push_back(mk(0,1,32'h100,32'h40,WR,4'h3,0,32'h0,      0,0,0,0,32'h0,32'h0,4'h0));
        vecs.push_back(mk(0,1,32'h100,32'h40,WR,4'h3,0,32'h0,      1,0,0,1,32'h40,WR,4'h3));
        vecs.push_back(mk(0,1,32'h100,32'h40,WR,4'h3,1,32'h0,      1,0,1,1,32'h40,WR,4'h3));
        vecs.push_back(mk(0,0,32'h100,32'h40,WR,4'h3,0,32'h0,      0,0,0,1,32'h0,32'h0,4'h0));
        // Owner drops valid mid-BUSY; the following tie proves last_served was kept
        vecs.push_back(mk(1,0,32'h100,32'h200,W1,4'hF,0,32'h0,     0,0,0,1,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,0,32'h100,32'h200,W1,4'hF,0,32'h0,     1,0,0,0,32'h100,W0,4'h0));
        vecs.push_back(mk(0,0,32'h100,32'h200,W1,4'hF,0,32'h0,     0,0,0,0,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,0,32'h0,     0,0,0,0,32'h0,32'h0,4'h0));
        vecs.push_back(mk(1,1,32'h100,32'h200,W1,4'hF,1,32'hB4,    1,1,0,0,32'h100,W0,4'h0));
        vecs.push_back(mk(0,0,32'h100,32'h200,W1,4'hF,0,32'h0,     0,0,0,0,32'h0,32'h0,4'h0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst s_valid", 32'(s_valid), 32'd0);
        chk("rst m0_ready", 32'(m0_ready), 32'd0);
        chk("rst m1_ready", 32'(m1_ready), 32'd0);
        chk("rst owner", 32'(owner), 32'd0);
        chk("rst timeout_err", 32'(timeout_err), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            m0_valid = vecs[i].m0v; m1_valid = vecs[i].m1v;
            m0_addr  = vecs[i].m0a; m1_addr  = vecs[i].m1a;
            m1_wdata = vecs[i].m1wd; m1_wstrb = vecs[i].m1ws;
            s_ready  = vecs[i].sr;  s_rdata  = vecs[i].srd;
            @(negedge clk);
            chk($sformatf("v%0d s_valid", i), 32'(s_valid), 32'(vecs[i].e_sv));
            chk($sformatf("v%0d m0_ready", i), 32'(m0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("v%0d m1_ready", i), 32'(m1_ready), 32'(vecs[i].e_r1));
            chk($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].e_own));
            chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].srd);
            chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].srd);
            if (vecs[i].e_sv) begin
                chk($sformatf("v%0d s_addr", i), s_addr, vecs[i].e_addr);
                chk($sformatf("v%0d s_wdata", i), s_wdata, vecs[i].e_wd);
                chk($sformatf("v%0d s_wstrb", i), 32'(s_wstrb), 32'(vecs[i].e_ws));
            end
            @(posedge clk);
            #1;
        end

        // Stalled memory: four BUSY wait cycles, then timeout (or normal completion without it)
        m0_valid = 1'b1; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h55;
        @(negedge clk);
        chk("to idle s_valid", 32'(s_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("to wait%0d s_valid", k), 32'(s_valid), 32'd1);
            chk($sformatf("to wait%0d m0_ready", k), 32'(m0_ready), 32'd0);
        end
        @(posedge clk); #1;
        s_ready = 1'b1;
        @(negedge clk);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("to hit s_valid", 32'(s_valid), 32'd0);
        chk("to hit m0_ready", 32'(m0_ready), 32'd1);
        chk("to hit m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to hit m1_rdata", m1_rdata, 32'h55);
        chk("to hit m1_ready", 32'(m1_ready), 32'd0);
`else
        chk("nto s_valid", 32'(s_valid), 32'd1);
        chk("nto m0_ready", 32'(m0_ready), 32'd1);
        chk("nto m0_rdata", m0_rdata, 32'h55);
`endif
        @(posedge clk); #1;
        m0_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        chk("to after s_valid", 32'(s_valid), 32'd0);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("to err set", 32'(timeout_err), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to err sticky", 32'(timeout_err), 32'd1);
`else
        chk("nto err", 32'(timeout_err), 32'd0);
`endif

        // Reset asserted while m1 owns the bus
        @(posedge clk); #1;
        m1_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb s_valid", 32'(s_valid), 32'd1);
        chk("rb owner", 32'(owner), 32'd1);
        #1 s_ready = 1'b1;
        #1 chk("rb m1_ready pre", 32'(m1_ready), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rb s_valid rst", 32'(s_valid), 32'd0);
        chk("rb m1_ready rst", 32'(m1_ready), 32'd0);
        chk("rb owner rst", 32'(owner), 32'd0);
        chk("rb err rst", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b0;
        @(negedge clk);
        chk("rb tie idle", 32'(s_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rb tie owner", 32'(owner), 32'd0);
        chk("rb tie s_valid", 32'(s_valid), 32'd1);
        chk("rb tie s_addr", s_addr, 32'h100);
        m0_valid = 1'b0; m1_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter
